cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Arbitrates completed functional-unit results onto the four common-data-bus forwarding channels (forwardA..forwardD) consumed by every reservation station.
- Up to NUM_REQ requesters (ALU, branch, load, mul, ...) compete each cycle. Up to four are granted using rotating (round-robin) priority.
- Granted results are broadcast from registered outputs one cycle later as {valid, rob tag, value}.

Parameters:
- NUM_REQ, 6, number of result requesters (2..8)
- TAG_W, 6, ROB tag width
- DATA_W, 16, result value width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- flush  input  1  pipeline squash; drop all in-flight broadcasts
- req_valid  input  NUM_REQ  requester i holds a result
- req_tag  input  NUM_REQ*TAG_W  packed ROB tags, requester i at [i*TAG_W +: TAG_W]
- req_data  input  NUM_REQ*DATA_W  packed values, same packing
- req_ready  output  NUM_REQ  combinational grant; result accepted this cycle
- forwardA  output  1+TAG_W+DATA_W  bus 0: [22] valid, [21:16] tag, [15:0] value (default widths)
- forwardB  output  same  bus 1
- forwardC  output  same  bus 2
- forwardD  output  same  bus 3

Behaviour:
- Reset, one cycle, synchronous active-high:
  - forwardA..D = 0.
  - rr_ptr = 0.
  - req_ready = 0 while reset is high.
- Grant is combinational from req_valid, rr_ptr, flush and reset.
  - Scan requesters from rr_ptr upward, modulo NUM_REQ.
  - The first four valid requesters found are granted.
  - req_ready[i] = 1 only if req_valid[i] and i is granted. A requester must hold valid, tag and data stable until ready.
- Bus assignment: the k-th granted requester in scan order (k = 0..3) drives bus k (A, B, C, D) in the next cycle.
- Latency: request granted in cycle N appears on forwardX with valid = 1 in cycle N+1. Each forward register holds for exactly one cycle.
- Unused buses: in cycle N+1, the valid bit = 0 and tag/value = 0.
- rr_ptr update:
  - When at least one grant occurs, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
  - With 4 or fewer valid requesters, all are granted in the same cycle.
  - Starvation is bounded: a continuously valid requester is granted within ceil(NUM_REQ/4) cycles.
- flush:
  - While high: req_ready = 0 and no grants.
  - Next cycle: all forward valid bits = 0, including results granted in the flush cycle's predecessor. These are cancelled in the cycle flush is sampled.
  - rr_ptr holds.
- Duplicate tags from two requesters are passed through unchanged. The arbiter does not check uniqueness.
- req_valid with no change across cycles: re-granted only if ready was 0. Each accepted handshake produces exactly one broadcast.
- Reset mid-operation: any pending broadcast is lost. Outputs read 0 in the cycle after reset is sampled.

Optional Feature:
- Macro CDB_STATS_EN, when defined, adds:
  - stat_bcast (output, 16): saturating count of total broadcasts.
  - stat_stall (output, 16): saturating count of cycles in which more than four requesters were valid and not flushed.
  - Both counters clear on reset and stick at 16'hFFFF.
- Without the macro: no stat ports and no counter logic. All other behaviour is identical.

Test Plan:
- Reset, then req_valid = 6'b000001, tag 6'h05, data 16'h1234 -> req_ready[0] = 1 in the same cycle; next cycle forwardA = {1, 6'h05, 16'h1234}, forwardB..D = 0; rr_ptr = 1.
- rr_ptr = 0, req_valid = 6'b111111 held for 3 cycles (with ready-driven deassertion/reassertion) -> cycle 1 grants 0..3 on A..D; cycle 2 grants 4, 5, 0, 1; cycle 3 grants 2, 3, 4, 5. Each result appears exactly once per accepted handshake.
- rr_ptr = 4, req_valid = 6'b010011 -> grants 4, 0, 1 on A, B, C; forwardD valid = 0; rr_ptr = 2.
- Grant in cycle N, flush = 1 in cycle N+1 -> forward outputs are still valid in N+1; in N+2 all valid bits = 0; req_ready = 0 during flush; rr_ptr unchanged.
- Reset asserted while requests are pending -> outputs 0 next cycle, rr_ptr = 0; a subsequent request from requester 3 is granted on forwardA.
- CDB_STATS_EN: 6 requesters valid for 2 cycles -> stat_stall = 1 (only the first cycle has more than four valid), stat_bcast = 6 after the second broadcast cycle; saturation holds at 16'hFFFF.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdb_arbiter_if : requester handshake and CDB forwarding bus bundle        |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
interface cdb_arbiter_if #(
   parameter int NUM_REQ = 6,
   parameter int TAG_W   = 6,
   parameter int DATA_W  = 16
);
   logic                        flush;
   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ*TAG_W-1:0]    req_tag;
   logic [NUM_REQ*DATA_W-1:0]   req_data;
   logic [NUM_REQ-1:0]          req_ready;
   logic [TAG_W+DATA_W:0]       forwardA;
   logic [TAG_W+DATA_W:0]       forwardB;
   logic [TAG_W+DATA_W:0]       forwardC;
   logic [TAG_W+DATA_W:0]       forwardD;

   modport master (
      output flush, req_valid, req_tag, req_data,
      input  req_ready, forwardA, forwardB, forwardC, forwardD
   );

   modport slave (
      input  flush, req_valid, req_tag, req_data,
      output req_ready, forwardA, forwardB, forwardC, forwardD
   );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdb_arbiter : round-robin grant of up to four results onto CDB A..D       |
// | Optional    : CDB_STATS_EN adds saturating broadcast/stall counters       |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module cdb_arbiter #(
   parameter int NUM_REQ = 6,
   parameter int TAG_W   = 6,
   parameter int DATA_W  = 16
) (
   input  wire logic     clk,
   input  wire logic     reset,
   cdb_arbiter_if.slave  bus
`ifdef CDB_STATS_EN
   ,
   output logic [15:0]   stat_bcast,
   output logic [15:0]   stat_stall
`endif
);
   localparam int PTR_W   = $clog2(NUM_REQ);
   localparam int FWD_W   = 1 + TAG_W + DATA_W;
   localparam int NUM_BUS = 4;
   localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

   logic [TAG_W-1:0]  tag_arr  [NUM_REQ];
   logic [DATA_W-1:0] data_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign tag_arr[i]  = bus.req_tag[i*TAG_W +: TAG_W];
      assign data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
   end

   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   rr_ptr_next;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_BUS-1:0] bus_used;
   logic [PTR_W-1:0]   bus_src [NUM_BUS];
   logic [2:0]         grant_cnt;
   logic [PTR_W:0]     scan_wide;
   logic [PTR_W-1:0]   scan_idx;

   // rr_ptr < NUM_REQ, so one conditional subtract wraps the scan index
   always_comb begin
      grant       = '0;
      bus_used    = '0;
      grant_cnt   = '0;
      rr_ptr_next = rr_ptr;
      scan_wide   = '0;
      scan_idx    = '0;
      for (int k = 0; k < NUM_BUS; k++) begin
         bus_src[k] = '0;
      end
      if (!reset && !bus.flush) begin
         for (int off = 0; off < NUM_REQ; off++) begin
            scan_wide = {1'b0, rr_ptr} + (PTR_W+1)'(off);
            if (scan_wide >= NUM_REQ_W) begin
               scan_wide = scan_wide - NUM_REQ_W;
            end
            scan_idx = scan_wide[PTR_W-1:0];
            if (bus.req_valid[scan_idx] && grant_cnt < 3'd4) begin
               grant[scan_idx]           = 1'b1;
               bus_used[grant_cnt[1:0]]  = 1'b1;
               bus_src[grant_cnt[1:0]]   = scan_idx;
               grant_cnt                 = grant_cnt + 3'd1;
               rr_ptr_next = (scan_idx == LAST_IDX) ? '0 : scan_idx + PTR_W'(1);
            end
         end
      end
   end

   assign bus.req_ready = grant;

   logic [FWD_W-1:0] fwd_q [NUM_BUS];

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
         for (int k = 0; k < NUM_BUS; k++) begin
            fwd_q[k] <= '0;
         end
      end else begin
         rr_ptr <= rr_ptr_next;
         for (int k = 0; k < NUM_BUS; k++) begin
            fwd_q[k] <= bus_used[k] ? {1'b1, tag_arr[bus_src[k]], data_arr[bus_src[k]]}
                                    : '0;
         end
      end
   end

   assign bus.forwardA = fwd_q[0];
   assign bus.forwardB = fwd_q[1];
   assign bus.forwardC = fwd_q[2];
   assign bus.forwardD = fwd_q[3];

`ifdef CDB_STATS_EN
   logic [3:0]  valid_cnt;
   logic [16:0] bcast_sum;

   always_comb begin
      valid_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         valid_cnt = valid_cnt + 4'(bus.req_valid[i]);
      end
   end

   assign bcast_sum = {1'b0, stat_bcast} + 17'(grant_cnt);

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_bcast <= '0;
         stat_stall <= '0;
      end else begin
         stat_bcast <= bcast_sum[16] ? 16'hFFFF : bcast_sum[15:0];
         if (!bus.flush && valid_cnt > 4'd4 && stat_stall != 16'hFFFF) begin
            stat_stall <= stat_stall + 16'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cdb_arbiter : directed + randomized check against a rotating-scan model|
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_cdb_arbiter;
   localparam int NUM_REQ = 6;
   localparam int TAG_W   = 6;
   localparam int DATA_W  = 16;
   localparam int FW      = 1 + TAG_W + DATA_W;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic chk_en = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

`ifdef CDB_STATS_EN
   logic [15:0] stat_bcast, stat_stall;
`endif

   cdb_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef CDB_STATS_EN
      ,
      .stat_bcast (stat_bcast),
      .stat_stall (stat_stall)
`endif
   );

   always #5 clk = ~clk;

   logic [FW-1:0] dut_fwd [4];
   assign dut_fwd[0] = bus.forwardA;
   assign dut_fwd[1] = bus.forwardB;
   assign dut_fwd[2] = bus.forwardC;
   assign dut_fwd[3] = bus.forwardD;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference: valid requesters listed in rotated order from the pointer,
   // the first four (in list order) take buses A..D one cycle later.
   logic [FW-1:0] exp_fwd [4];
   int            mptr;
   int            order[$];
   int            ng;
   logic [NUM_REQ-1:0] eg;
   logic [FW-1:0] nf [4];
`ifdef CDB_STATS_EN
   int exp_bcast = 0;
   int exp_stall = 0;
`endif

   always @(negedge clk) begin
      order.delete();
      eg = '0;
      for (int b = 0; b < 4; b++) nf[b] = '0;
      if (!reset && !bus.flush) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (bus.req_valid[(mptr + k) % NUM_REQ]) order.push_back((mptr + k) % NUM_REQ);
         end
      end
      ng = (order.size() > 4) ? 4 : order.size();
      for (int g = 0; g < ng; g++) begin
         eg[order[g]] = 1'b1;
         nf[g] = {1'b1, bus.req_tag[order[g]*TAG_W +: TAG_W], bus.req_data[order[g]*DATA_W +: DATA_W]};
      end
      if (chk_en) begin
         for (int b = 0; b < 4; b++) check($sformatf("model_fwd%0d", b), 32'(dut_fwd[b]), 32'(exp_fwd[b]));
         check("model_ready", 32'(bus.req_ready), 32'(eg));
`ifdef CDB_STATS_EN
         check("model_bcast", 32'(stat_bcast), exp_bcast);
         check("model_stall", 32'(stat_stall), exp_stall);
`endif
      end
      if (reset) begin
         mptr = 0;
         for (int b = 0; b < 4; b++) exp_fwd[b] = '0;
`ifdef CDB_STATS_EN
         exp_bcast = 0;
         exp_stall = 0;
`endif
      end else begin
         for (int b = 0; b < 4; b++) exp_fwd[b] = nf[b];
         if (ng > 0) mptr = (order[ng-1] + 1) % NUM_REQ;
`ifdef CDB_STATS_EN
         exp_bcast = (exp_bcast + ng > 65535) ? 65535 : exp_bcast + ng;
         if (!bus.flush && $countones(bus.req_valid) > 4 && exp_stall < 65535) exp_stall++;
`endif
      end
   end

   logic [NUM_REQ-1:0] pv;
   logic [TAG_W-1:0]   ptag  [NUM_REQ];
   logic [DATA_W-1:0]  pdata [NUM_REQ];
   logic [NUM_REQ-1:0] acc;

   task automatic drive_fields();
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_tag[i*TAG_W +: TAG_W]    = ptag[i];
         bus.req_data[i*DATA_W +: DATA_W] = pdata[i];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.flush     = 1'b0;
      bus.req_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ptag[i]  = TAG_W'(8 + i);
         pdata[i] = DATA_W'(16'hA000 + i);
      end
      ptag[0]  = 6'h05;
      pdata[0] = 16'h1234;
      drive_fields();
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_fwdA", 32'(bus.forwardA), 32'h0);
      check("reset_fwdD", 32'(bus.forwardD), 32'h0);

      // single requester
      tick(); bus.req_valid = 6'b000001;
      @(negedge clk); check("t1_ready", 32'(bus.req_ready), 32'h01);
      tick(); bus.req_valid = '0;
      @(negedge clk);
      check("t1_fwdA", 32'(bus.forwardA), 32'h451234);
      check("t1_fwdB", 32'(bus.forwardB), 32'h0);

      // all six from pointer 1, ready-driven deassertion
      ptag[0] = 6'd8; pdata[0] = 16'hA000; drive_fields();
      tick(); bus.req_valid = 6'b111111;
      @(negedge clk); check("t2_ready1", 32'(bus.req_ready), 32'h1E);
      tick(); bus.req_valid = 6'b100001;
      @(negedge clk);
      check("t2_ready2", 32'(bus.req_ready), 32'h21);
      check("t2_fwdA_tag", 32'(bus.forwardA[DATA_W +: TAG_W]), 32'd9);
      check("t2_fwdD", 32'(bus.forwardD), 32'h4CA004);
      tick(); bus.req_valid = '0;
      @(negedge clk);
      check("t2_fwdA_tag2", 32'(bus.forwardA[DATA_W +: TAG_W]), 32'd13);
      check("t2_fwdB_tag2", 32'(bus.forwardB[DATA_W +: TAG_W]), 32'd8);
      check("t2_fwdC_idle", 32'(bus.forwardC), 32'h0);

      // flush one cycle after a grant
      tick(); bus.req_valid = 6'b000100;
      @(negedge clk); check("t3_ready", 32'(bus.req_ready), 32'h04);
      tick(); bus.flush = 1'b1; bus.req_valid = 6'b001000;
      @(negedge clk);
      check("t3_flush_ready", 32'(bus.req_ready), 32'h0);
      check("t3_fwdA_live", 32'(bus.forwardA), 32'h4AA002);
      tick(); bus.flush = 1'b0; bus.req_valid = '0;
      @(negedge clk); check("t3_fwdA_flushed", 32'(bus.forwardA), 32'h0);
      tick(); bus.req_valid = 6'b001001;
      @(negedge clk); check("t3_ready_after", 32'(bus.req_ready), 32'h09);
      tick(); bus.req_valid = '0;
      @(negedge clk);
      check("t3_fwdA_ptr", 32'(bus.forwardA[DATA_W +: TAG_W]), 32'd11);
      check("t3_fwdB_ptr", 32'(bus.forwardB[DATA_W +: TAG_W]), 32'd8);

      // reset with requests pending
      tick(); reset = 1'b1; bus.req_valid = 6'b111111;
      @(negedge clk); check("t4_reset_ready", 32'(bus.req_ready), 32'h0);
      tick(); reset = 1'b0; bus.req_valid = 6'b001000;
      @(negedge clk);
      check("t4_fwdA_zero", 32'(bus.forwardA), 32'h0);
      check("t4_ready3", 32'(bus.req_ready), 32'h08);
      tick(); bus.req_valid = '0;
      @(negedge clk); check("t4_fwdA_req3", 32'(bus.forwardA), 32'h4BA003);

      // pointer 4 with requesters 4, 1, 0
      tick(); bus.req_valid = 6'b010011;
      @(negedge clk); check("t5_ready", 32'(bus.req_ready), 32'h13);
      tick(); bus.req_valid = '0;
      @(negedge clk);
      check("t5_fwdA_tag", 32'(bus.forwardA[DATA_W +: TAG_W]), 32'd12);
      check("t5_fwdC_tag", 32'(bus.forwardC[DATA_W +: TAG_W]), 32'd9);
      check("t5_fwdD_idle", 32'(bus.forwardD), 32'h0);

      // randomized traffic with flushes and occasional resets
      pv = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         acc = bus.req_ready;
         tick();
         for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i] || (!pv[i] && $urandom_range(99, 0) < 55)) begin
               pv[i]    = acc[i] ? 1'($urandom_range(1, 0)) : 1'b1;
               ptag[i]  = TAG_W'($urandom_range(63, 0));
               pdata[i] = DATA_W'($urandom);
            end
         end
         drive_fields();
         bus.req_valid = pv;
         bus.flush     = ($urandom_range(15, 0) == 0);
         reset         = ($urandom_range(199, 0) == 0);
      end
      tick();
      reset = 1'b0; bus.flush = 1'b0; bus.req_valid = '0;
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
